// File: rtl/hms_ctrl_pkg.sv
// Shared mode/position encodings and display blink-field masks for the HMS mode controller.
package hms_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SETUP = 2'd1,
        MODE_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_e;

    localparam logic [5:0] BLINK_SEC  = 6'b000011;
    localparam logic [5:0] BLINK_MIN  = 6'b001100;
    localparam logic [5:0] BLINK_HOUR = 6'b110000;

    function automatic logic [5:0] field_mask(input pos_e pos);
        logic [5:0] mask;
        case (pos)
            POS_SEC:  mask = BLINK_SEC;
            POS_MIN:  mask = BLINK_MIN;
            POS_HOUR: mask = BLINK_HOUR;
            default:  mask = 6'b000000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/hms_mode_ctrl_sw_press_det.sv
// Button front end: 2-FF synchronizer, strobe-sampled debounce and a 1-clk press pulse
// on the sample pattern high, low, low.
module sw_press_det (
    input  logic clk,
    input  logic rst_n,
    input  logic smp_stb,
    input  logic sw_n,
    output logic press,
    output logic level_low
);

    logic       sync1_q, sync2_q;
    logic [1:0] hist_q, hist_d;
    logic       press_q, press_d;

    // History resets to "low" so a button held through reset never shows the high sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 2'b00;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sw_n;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        press_d = 1'b0;
        if (smp_stb) begin
            hist_d  = {hist_q[0], sync2_q};
            press_d = hist_q[1] & ~hist_q[0] & ~sync2_q;
        end
    end

    assign press     = press_q;
    assign level_low = ~hist_q[0];

endmodule

// File: rtl/hms_mode_ctrl.sv
// HMS clock mode/sequencing controller: debounced buttons, CLOCK/SETUP/ALARM FSM, count enables
// and blink mask. Define HMS_AUTO_REPEAT_EN to enable auto-repeat on the increment button.
module hms_mode_ctrl
    import hms_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned SMP_DIV   = 500000,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned REP_DLY   = 50,
    parameter int unsigned REP_PER   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sec_at_max,
    input  logic       i_min_at_max,
    output logic [1:0] o_mode,
    output logic [1:0] o_position,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hour_en,
    output logic       o_alm_min_en,
    output logic       o_alm_hour_en,
    output logic [5:0] o_blink_mask
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SmpW   = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
    localparam logic [SmpW-1:0]   SmpMax   = SmpW'(SMP_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

    logic [SmpW-1:0]   smp_cnt_q, smp_cnt_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    mode_e             mode_q, mode_d;
    pos_e              pos_q, pos_d;

    logic smp_stb, tick;
    logic sw0_press, sw1_press, sw2_press;
    logic sw0_low, sw1_low, sw2_low;
    logic act_mode, act_pos, act_inc, any_press, inc_pulse;

    assign smp_stb = (smp_cnt_q == SmpMax);

    sw_press_det u_sw0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_stb   (smp_stb),
        .sw_n      (i_sw0),
        .press     (sw0_press),
        .level_low (sw0_low)
    );

    sw_press_det u_sw1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_stb   (smp_stb),
        .sw_n      (i_sw1),
        .press     (sw1_press),
        .level_low (sw1_low)
    );

    sw_press_det u_sw2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_stb   (smp_stb),
        .sw_n      (i_sw2),
        .press     (sw2_press),
        .level_low (sw2_low)
    );

    logic unused_levels;
    assign unused_levels = ^{sw0_low, sw1_low};

    // Priority: mode beats position beats increment; losers are dropped.
    assign act_mode  = sw0_press;
    assign act_pos   = sw1_press & ~sw0_press;
    assign act_inc   = sw2_press & ~sw0_press & ~sw1_press;
    assign any_press = sw0_press | sw1_press | sw2_press;

`ifdef HMS_AUTO_REPEAT_EN
    localparam int unsigned RepMax = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_tgt;
    logic            rep_act_q, rep_act_d, rep_first_q, rep_first_d, rep_pulse;
    logic            stb_dly_q;

    // Press pulses land one cycle after the strobe, so the repeat logic uses a delayed strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            stb_dly_q   <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            stb_dly_q   <= smp_stb;
        end
    end

    assign rep_tgt = rep_first_q ? RepW'(REP_DLY) : RepW'(REP_PER);

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_act_d   = rep_act_q;
        rep_first_d = rep_first_q;
        rep_pulse   = 1'b0;
        if (act_mode || act_pos) begin
            rep_act_d = 1'b0;
        end else if (act_inc) begin
            rep_act_d   = (mode_q != MODE_CLOCK);
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (rep_act_q && stb_dly_q) begin
            if (!sw2_low) begin
                rep_act_d = 1'b0;
            end else if ((rep_cnt_q + RepW'(1)) == rep_tgt) begin
                rep_pulse   = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
    end

    assign inc_pulse = act_inc | rep_pulse;
`else
    logic unused_rep;
    assign unused_rep = ^{sw2_low, REP_DLY[0], REP_PER[0]};
    assign inc_pulse  = act_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode_q      <= MODE_CLOCK;
            pos_q       <= POS_SEC;
        end else begin
            smp_cnt_q   <= smp_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            pos_q       <= pos_d;
        end
    end

    always_comb begin
        smp_cnt_d = smp_stb ? '0 : smp_cnt_q + SmpW'(1);

        // Held at zero in SETUP so the first tick after leaving it is a full period.
        if (mode_q == MODE_SETUP || tick_cnt_q == TickMax) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
        end

        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        phase_d     = phase_q;
        if (mode_q == MODE_CLOCK || any_press) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        if (act_mode) begin
            case (mode_q)
                MODE_CLOCK: begin
                    mode_d = MODE_SETUP;
                    pos_d  = POS_SEC;
                end
                MODE_SETUP: begin
                    mode_d = MODE_ALARM;
                    pos_d  = POS_MIN;
                end
                default: mode_d = MODE_CLOCK;
            endcase
        end else if (act_pos) begin
            if (mode_q == MODE_SETUP) begin
                case (pos_q)
                    POS_SEC: pos_d = POS_MIN;
                    POS_MIN: pos_d = POS_HOUR;
                    default: pos_d = POS_SEC;
                endcase
            end else if (mode_q == MODE_ALARM) begin
                case (pos_q)
                    POS_MIN: pos_d = POS_HOUR;
                    default: pos_d = POS_MIN;
                endcase
            end
        end
    end

    assign tick = (mode_q != MODE_SETUP) && (tick_cnt_q == TickMax);

    always_comb begin
        o_sec_en      = 1'b0;
        o_min_en      = 1'b0;
        o_hour_en     = 1'b0;
        o_alm_min_en  = 1'b0;
        o_alm_hour_en = 1'b0;
        if (mode_q == MODE_SETUP) begin
            // Manual set: one field only, never a carry.
            o_sec_en  = inc_pulse && (pos_q == POS_SEC);
            o_min_en  = inc_pulse && (pos_q == POS_MIN);
            o_hour_en = inc_pulse && (pos_q == POS_HOUR);
        end else begin
            o_sec_en  = tick;
            o_min_en  = tick & i_sec_at_max;
            o_hour_en = o_min_en & i_min_at_max;
            if (mode_q == MODE_ALARM) begin
                o_alm_min_en  = inc_pulse && (pos_q == POS_MIN);
                o_alm_hour_en = inc_pulse && (pos_q == POS_HOUR);
            end
        end
    end

    assign o_mode       = mode_q;
    assign o_position   = pos_q;
    assign o_blink_mask = (phase_q && mode_q != MODE_CLOCK) ? field_mask(pos_q) : 6'b000000;

endmodule

// File: tb/tb_hms_mode_ctrl.sv
// Directed self-checking bench for hms_mode_ctrl with small divider values.
module tb_hms_mode_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw_n;
    logic       sec_max, min_max;
    logic [1:0] mode, position;
    logic       sec_en, min_en, hour_en, alm_min_en, alm_hour_en;
    logic [5:0] blink_mask;

    int errors = 0;
    int checks = 0;

    int n_sec = 0, n_min = 0, n_hour = 0, n_amin = 0, n_ahour = 0, n_all3 = 0;
    int n_mask_nz = 0, n_mask_sec = 0;
    int s_sec, s_min, s_hour, s_amin, s_ahour, s_all3, s_mask_nz, s_mask_sec;
    int exp_rep;

    hms_mode_ctrl #(
        .TICK_DIV  (20),
        .SMP_DIV   (4),
        .BLINK_DIV (8),
        .REP_DLY   (3),
        .REP_PER   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sw0         (sw_n[0]),
        .i_sw1         (sw_n[1]),
        .i_sw2         (sw_n[2]),
        .i_sec_at_max  (sec_max),
        .i_min_at_max  (min_max),
        .o_mode        (mode),
        .o_position    (position),
        .o_sec_en      (sec_en),
        .o_min_en      (min_en),
        .o_hour_en     (hour_en),
        .o_alm_min_en  (alm_min_en),
        .o_alm_hour_en (alm_hour_en),
        .o_blink_mask  (blink_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sec_en) n_sec++;
        if (min_en) n_min++;
        if (hour_en) n_hour++;
        if (alm_min_en) n_amin++;
        if (alm_hour_en) n_ahour++;
        if (sec_en && min_en && hour_en) n_all3++;
        if (blink_mask != 6'b000000) n_mask_nz++;
        if (blink_mask == 6'b000011) n_mask_sec++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic snap();
        s_sec = n_sec; s_min = n_min; s_hour = n_hour;
        s_amin = n_amin; s_ahour = n_ahour; s_all3 = n_all3;
        s_mask_nz = n_mask_nz; s_mask_sec = n_mask_sec;
    endtask

    task automatic press(input int b);
        sw_n[b] = 1'b0;
        clks(16);
        sw_n[b] = 1'b1;
        clks(24);
    endtask

    initial begin
        sw_n    = 3'b111;
        sec_max = 1'b0;
        min_max = 1'b0;
        rst_n   = 1'b0;
        clks(3);
        @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_pos", position, 0);
        check("rst_en", {sec_en, min_en, hour_en, alm_min_en, alm_hour_en}, 0);
        check("rst_mask", blink_mask, 0);
        rst_n = 1'b1;

        // CLOCK: free-running ticks, no carry, no blink
        snap();
        clks(200);
        check("clk_sec", n_sec - s_sec, 10);
        check("clk_min", n_min - s_min, 0);
        check("clk_hour", n_hour - s_hour, 0);
        check("clk_mask", n_mask_nz - s_mask_nz, 0);

        sec_max = 1'b1;
        snap();
        clks(40);
        check("carry_min", n_min - s_min, 2);
        check("carry_nohour", n_hour - s_hour, 0);
        min_max = 1'b1;
        snap();
        clks(40);
        check("carry_all3", n_all3 - s_all3, 2);
        check("carry_sec", n_sec - s_sec, 2);

        // SETUP
        press(0);
        check("setup_mode", mode, 1);
        check("setup_pos", position, 0);
        snap();
        clks(200);
        check("setup_notick", n_sec - s_sec, 0);
        snap();
        press(2);
        press(2);
        press(2);
        check("setup_inc_sec", n_sec - s_sec, 3);
        check("setup_nocarry", n_min - s_min, 0);
        check("setup_nohour", n_hour - s_hour, 0);
        snap();
        clks(64);
        check("blink_nz", n_mask_nz - s_mask_nz, 32);
        check("blink_sec", n_mask_sec - s_mask_sec, 32);

        press(1);
        press(1);
        check("setup_pos_hour", position, 2);
        snap();
        press(2);
        check("setup_inc_hour", n_hour - s_hour, 1);
        check("setup_hour_only", (n_sec - s_sec) + (n_min - s_min), 0);

        // ALARM
        sec_max = 1'b0;
        min_max = 1'b0;
        press(0);
        check("alarm_mode", mode, 2);
        check("alarm_pos", position, 1);
        snap();
        press(2);
        check("alarm_amin", n_amin - s_amin, 1);
        check("alarm_ahour", n_ahour - s_ahour, 0);
        snap();
        clks(100);
        check("alarm_ticks", n_sec - s_sec, 5);

        // Held sw2: 22 low samples, i.e. the press plus 20 more
`ifdef HMS_AUTO_REPEAT_EN
        exp_rep = 10;
`else
        exp_rep = 1;
`endif
        snap();
        sw_n[2] = 1'b0;
        clks(88);
        sw_n[2] = 1'b1;
        clks(40);
        check("repeat_amin", n_amin - s_amin, exp_rep);

        press(1);
        check("alarm_pos_hour", position, 2);
        snap();
        press(2);
        check("alarm_ahour_inc", n_ahour - s_ahour, 1);
        check("alarm_ahour_nomin", n_amin - s_amin, 0);

        press(0);
        check("back_clock", mode, 0);
        press(0);
        press(1);
        check("setup2_pos_min", position, 1);

        // sw0 and sw2 together: mode wins, increment dropped
        snap();
        sw_n = 3'b010;
        clks(16);
        sw_n = 3'b111;
        clks(24);
        check("simul_mode", mode, 2);
        check("simul_pos", position, 1);
        check("simul_nomin", n_min - s_min, 0);
        check("simul_noalm", (n_amin - s_amin) + (n_ahour - s_ahour), 0);

        // One-sample glitch
        sw_n[0] = 1'b0;
        clks(4);
        sw_n[0] = 1'b1;
        clks(30);
        check("glitch_mode", mode, 2);

        // Button held through reset
        sw_n[0] = 1'b0;
        clks(20);
        rst_n = 1'b0;
        clks(5);
        @(negedge clk);
        check("rst2_mode", mode, 0);
        check("rst2_mask", blink_mask, 0);
        rst_n = 1'b1;
        clks(20);
        sw_n[0] = 1'b1;
        clks(30);
        check("held_rst_nopress", mode, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
